stream_sorter: RTL and testbench
================================

STREAM_SORTER -- requirements
Module: stream_sorter

Interface
REQ-001 SHALL have parameter N, default 32, meaning entries per frame (power of 2, 4..64).
REQ-002 SHALL have parameter W, default 29, meaning entry width in bits.
REQ-003 SHALL have parameter KEY_W, default 24, meaning sort key = entry[KEY_W-1:0] (KEY_W <= W).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  in  1  input entry valid.
REQ-007 SHALL have port in_ready  out  1  sorter accepts input.
REQ-008 SHALL have port in_data  in  W  input entry.
REQ-009 SHALL have port in_last  in  1  marks final entry of frame.
REQ-010 SHALL have port desc  in  1  sort order, 1 = descending; sampled with first entry of frame.
REQ-011 SHALL have port out_valid  out  1  sorted entry valid.
REQ-012 SHALL have port out_ready  in  1  downstream accepts output.
REQ-013 SHALL have port out_data  out  W  sorted entry.
REQ-014 SHALL have port out_last  out  1  marks final sorted entry.
REQ-015 SHALL have port busy  out  1  high in SORT or DRAIN.

Function
REQ-016 SHALL implement FSM IDLE -> LOAD -> SORT -> DRAIN -> IDLE.
REQ-017 Transfer SHALL occur on in_valid & in_ready (input) and out_valid & out_ready (output).
REQ-018 in_ready SHALL be 1 exactly in IDLE and LOAD.
REQ-019 IDLE: first transfer writes slot 0, latches desc, sets slot valid bit, goes to LOAD (or SORT if in_last).
REQ-020 LOAD: each transfer writes next slot; frame closes on in_last or on the Nth entry (in_last ignored after that); next state SORT.
REQ-021 Unfilled slots SHALL be marked invalid; invalid slots always order after valid slots.
REQ-022 SORT SHALL run odd-even transposition: phase p (0..N-1) compares pairs (i,i+1) with i even for even p, odd for odd p; exactly N cycles.
REQ-023 Swap SHALL occur only when the pair is strictly out of order (asc: key[i] > key[i+1]; desc: key[i] < key[i+1]), giving a stable sort; equal keys keep arrival order.
REQ-024 Keys SHALL compare as unsigned; non-key bits [W-1:KEY_W] travel unchanged with their entry.
REQ-025 DRAIN: out_valid = 1, out_data = slot at read pointer; pointer advances on each output transfer.
REQ-026 out_data/out_valid/out_last SHALL hold stable while out_valid & !out_ready.
REQ-027 out_last SHALL be 1 on the entry at index count-1, count = entries received (1..N).
REQ-028 After output transfer with out_last, state SHALL return to IDLE and clear all slot valid bits.
REQ-029 Latency: first out_valid SHALL assert N+1 cycles after the cycle the closing input transfer occurs.
REQ-030 A new frame SHALL NOT be accepted until the previous frame fully drains (no overlap).
REQ-031 busy SHALL be 1 in SORT and DRAIN, 0 otherwise.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, in_ready 0, out_valid 0, out_last 0, busy 0, out_data 0, counters 0, slot valid bits 0.
REQ-033 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-034 Reset mid-LOAD/SORT/DRAIN SHALL discard the frame; no partial output afterwards.

Structure
REQ-035 Package sort_pkg SHALL hold the FSM state enum and default N, W, KEY_W.
REQ-036 A single sub-module sort_cmp_swap (one compare-exchange cell: two entries, two valid bits, desc, swap result) SHALL be instantiated N/2 times per phase type.
REQ-037 Slot storage SHALL be flip-flops (all pairs accessed in parallel).

Verification
REQ-038 Full frame, asc: N=32, keys 31..0 with index in upper bits, out_ready=1 -> outputs keys 0..31, out_last on 32nd, first out_valid 33 cycles after last input.
REQ-039 Stability/desc: 8 entries keys {5,5,3,5,3,9,9,1}, desc=1 -> keys 9,9,5,5,5,3,3,1 with equal keys in arrival order (check upper bits).
REQ-040 Short frame: 3 entries keys {7,2,4}, in_last on 3rd -> exactly 3 outputs 2,4,7, out_last on 3rd, no padding emitted.
REQ-041 Backpressure: out_ready toggled 1/0 randomly -> no drop/duplicate, out_data stable while stalled; in_ready=0 throughout SORT/DRAIN.
REQ-042 Reset mid-SORT: assert rst_n low during phase 10 -> all outputs 0 immediately; next frame {1,0} sorts to 0,1 with no stale data.
REQ-043 Overflow: 34 entries streamed, in_last never asserted -> frame closes at 32nd, in_ready falls, out_last on 32nd output.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and default geometry for the stream sorter.
package sort_pkg;

    localparam int unsigned DEF_N     = 32;
    localparam int unsigned DEF_W     = 29;
    localparam int unsigned DEF_KEY_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SORT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/sort_cmp_swap.sv
// One compare-exchange decision: flags when the pair (a,b) is strictly out of order.
module sort_cmp_swap #(
    parameter int unsigned KEY_W = 24
) (
    input  logic [KEY_W-1:0] a_key,
    input  logic [KEY_W-1:0] b_key,
    input  logic             a_vld,
    input  logic             b_vld,
    input  logic             desc,
    output logic             swap_c
);

    // Empty slots sink behind populated ones; equal keys never swap so order is stable.
    always_comb begin
        swap_c = 1'b0;
        if (a_vld && b_vld) begin
            swap_c = desc ? (a_key < b_key) : (a_key > b_key);
        end else if (!a_vld && b_vld) begin
            swap_c = 1'b1;
        end
    end

endmodule

// File: rtl/stream_sorter.sv
// Frame sorter: loads up to N entries, runs N odd-even transposition phases, drains in order.
module stream_sorter
    import sort_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned W     = DEF_W,
    parameter int unsigned KEY_W = DEF_KEY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    input  logic         desc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int unsigned PTR_W = $clog2(N);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned HALF  = N / 2;

    state_e           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] rd_ptr, rd_nx;
    logic [PTR_W-1:0] phase, phase_nx;
    logic             desc_q, desc_nx;
    logic             in_ready_nx, busy_nx, out_valid_nx, out_last_nx;
    logic [W-1:0]     out_data_nx;
    logic             wr_en, sort_en, clr_vld, load_out;
    logic             in_fire, out_fire;
    logic [PTR_W-1:0] wr_idx;

    logic [W-1:0]     slot_data [N];
    logic             slot_vld  [N];
    logic [HALF-1:0]  swp_e, swp_o;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign wr_idx   = cnt[PTR_W-1:0];

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rd_ptr    <= '0;
            phase     <= '0;
            desc_q    <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rd_ptr    <= rd_nx;
            phase     <= phase_nx;
            desc_q    <= desc_nx;
            in_ready  <= in_ready_nx;
            busy      <= busy_nx;
            out_valid <= out_valid_nx;
            out_last  <= out_last_nx;
            out_data  <= out_data_nx;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        rd_nx        = rd_ptr;
        phase_nx     = phase;
        desc_nx      = desc_q;
        out_valid_nx = out_valid;
        out_last_nx  = out_last;
        out_data_nx  = out_data;
        wr_en        = 1'b0;
        sort_en      = 1'b0;
        clr_vld      = 1'b0;
        load_out     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (in_fire) begin
                    wr_en    = 1'b1;
                    desc_nx  = desc;
                    cnt_nx   = CNT_W'(1);
                    phase_nx = '0;
                    state_nx = in_last ? ST_SORT : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_fire) begin
                    wr_en  = 1'b1;
                    cnt_nx = cnt + CNT_W'(1);
                    // Nth entry closes the frame regardless of in_last
                    if (in_last || (cnt == CNT_W'(N - 1))) begin
                        phase_nx = '0;
                        state_nx = ST_SORT;
                    end
                end
            end
            ST_SORT: begin
                sort_en  = 1'b1;
                phase_nx = phase + PTR_W'(1);
                if (phase == PTR_W'(N - 1)) begin
                    rd_nx    = '0;
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid) begin
                    load_out = 1'b1;
                end else if (out_fire) begin
                    if (out_last) begin
                        out_valid_nx = 1'b0;
                        out_last_nx  = 1'b0;
                        out_data_nx  = '0;
                        cnt_nx       = '0;
                        rd_nx        = '0;
                        clr_vld      = 1'b1;
                        state_nx     = ST_IDLE;
                    end else begin
                        load_out = 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (load_out) begin
            out_valid_nx = 1'b1;
            out_data_nx  = slot_data[rd_ptr[PTR_W-1:0]];
            out_last_nx  = (rd_ptr == (cnt - CNT_W'(1)));
            rd_nx        = rd_ptr + CNT_W'(1);
        end

        in_ready_nx = (state_nx == ST_IDLE) || (state_nx == ST_LOAD);
        busy_nx     = (state_nx == ST_SORT) || (state_nx == ST_DRAIN);
    end

    // Compare-exchange cells; the last odd cell faces a permanently empty pad slot
    for (genvar k = 0; k < HALF; k++) begin : g_cell
        sort_cmp_swap #(.KEY_W(KEY_W)) u_even (
            .a_key  (slot_data[2*k][KEY_W-1:0]),
            .b_key  (slot_data[2*k+1][KEY_W-1:0]),
            .a_vld  (slot_vld[2*k]),
            .b_vld  (slot_vld[2*k+1]),
            .desc   (desc_q),
            .swap_c (swp_e[k])
        );
        if (k < HALF - 1) begin : g_odd
            sort_cmp_swap #(.KEY_W(KEY_W)) u_odd (
                .a_key  (slot_data[2*k+1][KEY_W-1:0]),
                .b_key  (slot_data[2*k+2][KEY_W-1:0]),
                .a_vld  (slot_vld[2*k+1]),
                .b_vld  (slot_vld[2*k+2]),
                .desc   (desc_q),
                .swap_c (swp_o[k])
            );
        end else begin : g_pad
            sort_cmp_swap #(.KEY_W(KEY_W)) u_odd (
                .a_key  (slot_data[2*k+1][KEY_W-1:0]),
                .b_key  ('0),
                .a_vld  (slot_vld[2*k+1]),
                .b_vld  (1'b0),
                .desc   (desc_q),
                .swap_c (swp_o[k])
            );
        end
    end

    // Per-slot storage: each slot picks its partner for the current phase parity
    for (genvar i = 0; i < N; i++) begin : g_slot
        logic         e_swp, o_swp;
        logic [W-1:0] e_d, o_d;
        logic         e_v, o_v;

        if (i % 2 == 0) begin : g_ev
            assign e_swp = swp_e[i/2];
            assign e_d   = slot_data[i+1];
            assign e_v   = slot_vld[i+1];
            if (i == 0) begin : g_first
                assign o_swp = 1'b0;
                assign o_d   = slot_data[i];
                assign o_v   = slot_vld[i];
            end else begin : g_mid
                assign o_swp = swp_o[i/2-1];
                assign o_d   = slot_data[i-1];
                assign o_v   = slot_vld[i-1];
            end
        end else begin : g_od
            assign e_swp = swp_e[i/2];
            assign e_d   = slot_data[i-1];
            assign e_v   = slot_vld[i-1];
            assign o_swp = swp_o[i/2];
            if (i == N - 1) begin : g_last
                assign o_d = '0;
                assign o_v = 1'b0;
            end else begin : g_mid
                assign o_d = slot_data[i+1];
                assign o_v = slot_vld[i+1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_data[i] <= '0;
                slot_vld[i]  <= 1'b0;
            end else begin
                if (wr_en && (wr_idx == PTR_W'(i))) begin
                    slot_data[i] <= in_data;
                    slot_vld[i]  <= 1'b1;
                end else if (sort_en && (phase[0] ? o_swp : e_swp)) begin
                    slot_data[i] <= phase[0] ? o_d : e_d;
                    slot_vld[i]  <= phase[0] ? o_v : e_v;
                end
                if (clr_vld) begin
                    slot_vld[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_sorter.sv
// Scoreboard bench for stream_sorter: stable reference sort of each frame, monitor checks outputs.
module tb_stream_sorter;

    localparam int unsigned N     = 32;
    localparam int unsigned W     = 29;
    localparam int unsigned KEY_W = 24;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         desc = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;

    stream_sorter #(.N(N), .W(W), .KEY_W(KEY_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .desc      (desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    exp_t         exp_q[$];
    int           close_q[$];
    logic [W-1:0] cur_q[$];
    logic         cur_desc;
    bit           bp_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] mk(input int idx, input int key);
        logic [W-1:0] r;
        r = '0;
        r[KEY_W-1:0] = KEY_W'(key);
        r[W-1:KEY_W] = (W-KEY_W)'(idx);
        return r;
    endfunction

    function automatic bit out_of_order(input logic [W-1:0] a, input logic [W-1:0] b, input logic d);
        return d ? (a[KEY_W-1:0] < b[KEY_W-1:0]) : (a[KEY_W-1:0] > b[KEY_W-1:0]);
    endfunction

    // Reference: stable insertion sort of the closed frame, queued as expected outputs
    task automatic model_close();
        logic [W-1:0] s[$];
        logic [W-1:0] t;
        s = cur_q;
        for (int i = 1; i < s.size(); i++) begin
            for (int j = i; j > 0 && out_of_order(s[j-1], s[j], cur_desc); j--) begin
                t = s[j]; s[j] = s[j-1]; s[j-1] = t;
            end
        end
        for (int i = 0; i < s.size(); i++) exp_q.push_back('{d: s[i], l: (i == s.size() - 1)});
        cur_q.delete();
        close_q.push_back(cyc);
    endtask

    // Present one entry until accepted; called just after a rising edge
    task automatic send(input logic [W-1:0] d, input logic l, input logic ds);
        bit fired;
        int n;
        fired = 0;
        n = 0;
        in_valid = 1'b1; in_data = d; in_last = l; desc = ds;
        while (!fired && n < 1000) begin
            @(negedge clk);
            if (in_ready) fired = 1;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!fired) begin
            checks++; failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end else begin
            if (cur_q.size() == 0) cur_desc = ds;
            cur_q.push_back(d);
            if (l || cur_q.size() == N) model_close();
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=pending%0d required=0", exp_q.size());
        end
    endtask

    // Random output backpressure when enabled
    initial forever begin
        @(posedge clk); #1;
        out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: latency, hold-while-stalled, input gating, and scoreboard pops
    logic         prev_ov = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;
    exp_t         mon_e;
    int           mon_c;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_data", 64'(out_data), 64'(prev_data));
                check("stall_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && !prev_ov) begin
                if (close_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL latency actual=unexpected_frame required=none");
                end else begin
                    mon_c = close_q.pop_front();
                    check("latency", 64'(cyc - mon_c), 64'(N + 1));
                end
            end
            if (busy) check("in_ready_while_busy", 64'(in_ready), 64'(0));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra_output actual=%0h required=none", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(mon_e.d));
                    check("out_last", 64'(out_last), 64'(mon_e.l));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            prev_ov    = out_valid;
        end
    end

    int keys8[8] = '{5, 5, 3, 5, 3, 9, 9, 1};
    int keys3[3] = '{7, 2, 4};

    initial begin
        int len;
        logic ds;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_before_edge", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        check("in_ready_first_edge", 64'(in_ready), 64'(1));

        // Full ascending frame, reversed keys
        for (int i = 0; i < 32; i++) send(mk(i, 31 - i), (i == 31), 1'b0);
        wait_drain();

        // Descending with duplicate keys: arrival order kept among equals
        for (int i = 0; i < 8; i++) send(mk(i, keys8[i]), (i == 7), 1'b1);
        wait_drain();

        // Short frame
        for (int i = 0; i < 3; i++) send(mk(i, keys3[i]), (i == 2), 1'b0);
        wait_drain();

        // Overflow: no in_last, frame closes at the Nth entry
        bp_mode = 1;
        for (int i = 0; i < 32; i++) send(mk(i, $urandom_range(0, 255)), 1'b0, 1'b0);
        check("ovf_in_ready_low", 64'(in_ready), 64'(0));
        check("ovf_busy", 64'(busy), 64'(1));
        send(mk(32, $urandom_range(0, 255)), 1'b0, 1'b1);
        send(mk(33, $urandom_range(0, 255)), 1'b0, 1'b0);
        send(mk(34, $urandom_range(0, 255)), 1'b1, 1'b0);
        wait_drain();

        // Random frames with backpressure, gaps, and desc wiggling after the first entry
        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(1, N);
            ds  = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                send(mk(i, (f % 2 == 0) ? $urandom_range(0, 7) : int'($urandom())),
                     (i == len - 1), (i == 0) ? ds : 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end
        wait_drain();

        // Reset during sort phase 10 discards the frame
        bp_mode = 0;
        for (int i = 0; i < 32; i++) send(mk(i, $urandom_range(0, 1000)), (i == 31), 1'b0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        close_q.delete();
        cur_q.delete();
        check("midsort_in_ready", 64'(in_ready), 64'(0));
        check("midsort_out_valid", 64'(out_valid), 64'(0));
        check("midsort_out_last", 64'(out_last), 64'(0));
        check("midsort_busy", 64'(busy), 64'(0));
        check("midsort_out_data", 64'(out_data), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        send(mk(1, 1), 1'b0, 1'b0);
        send(mk(2, 0), 1'b1, 1'b0);
        wait_drain();

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
